// File: rtl/minmax_pkg.sv
// Shared constants for the min/max frame scanner: default widths and FSM state encoding.
package minmax_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_CMP_MAX = 2'd1;
  localparam state_t S_CMP_MIN = 2'd2;
  localparam state_t S_DONE    = 2'd3;
endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator; purely combinational, no backpressure.
module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater,
  output logic             equal,
  output logic             less
);
  assign greater = (a > b);
  assign equal   = (a == b);
  assign less    = (a < b);
endmodule

// File: rtl/minmax_scanner.sv
// Per-frame running max/min/count/all-equal tracker sharing one comparator across two FSM steps.
// Result 2 cycles after a non-first last sample (same edge for single-sample frames); in_ready low outside IDLE, result held until out_ready.
module minmax_scanner
  import minmax_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_all_eq,
  output logic             busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] smp_r;
  logic             last_r;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] min_r;
  logic [CNT_W-1:0] count;
  logic             all_eq;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_greater;
  logic             cmp_equal;
  logic             cmp_less;
  logic             accept;
  logic             first;

  assign accept = in_valid && in_ready;
  assign first  = (count == '0);

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .a       (smp_r),
    .b       (cmp_b),
    .greater (cmp_greater),
    .equal   (cmp_equal),
    .less    (cmp_less)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (!first)       next_state = S_CMP_MAX;
          else if (in_last) next_state = S_DONE;
          else              next_state = S_IDLE;
        end
      end
      S_CMP_MAX: next_state = S_CMP_MIN;
      S_CMP_MIN: next_state = last_r ? S_DONE : S_IDLE;
      S_DONE:    if (out_ready) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE) || !first;
    // Only the min step looks at min_r; every other state parks the mux on max_r.
    cmp_b     = (state == S_CMP_MIN) ? min_r : max_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_r  <= '0;
      last_r <= 1'b0;
      max_r  <= '0;
      min_r  <= '0;
      count  <= '0;
      all_eq <= 1'b1;
    end else begin
      if (accept) begin
        smp_r  <= in_data;
        last_r <= in_last;
        if (first) begin
          max_r  <= in_data;
          min_r  <= in_data;
          count  <= {{(CNT_W-1){1'b0}}, 1'b1};
          all_eq <= 1'b1;
        end else if (count != CNT_MAX) begin
          count <= count + 1'b1;
        end
      end
      if (state == S_CMP_MAX) begin
        if (cmp_greater) max_r  <= smp_r;
        if (!cmp_equal)  all_eq <= 1'b0;
      end
      if (state == S_CMP_MIN && cmp_less) min_r <= smp_r;
      // max_r/min_r stay visible after delivery until the next frame's first sample.
      if (state == S_DONE && out_ready) begin
        count  <= '0;
        all_eq <= 1'b1;
      end
    end
  end

  assign out_max    = max_r;
  assign out_min    = min_r;
  assign out_count  = count;
  assign out_all_eq = all_eq;
endmodule

// File: tb/tb_minmax_scanner.sv
// Directed self-checking bench for minmax_scanner; a second instance with CNT_W=2 shares the stimulus.
module tb_minmax_scanner;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [7:0] out_count;
  logic       out_all_eq;
  logic       busy;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [3:0] s_out_max;
  logic [3:0] s_out_min;
  logic [1:0] s_out_count;
  logic       s_out_all_eq;
  logic       s_busy;

  int checks = 0;
  int passed = 0;

  minmax_scanner #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
    .out_count(out_count), .out_all_eq(out_all_eq), .busy(busy)
  );

  minmax_scanner #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_max(s_out_max), .out_min(s_out_min),
    .out_count(s_out_count), .out_all_eq(s_out_all_eq), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Offers one sample and returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [3:0] d, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      $display("FAIL done_timeout: out_valid got 0 want 1");
    end
    @(negedge clk);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready: got %0d want 1", in_ready);   else passed++;
    checks++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid: got %0d want 0", out_valid); else passed++;
    checks++; if (out_max !== 4'd0)    $display("FAIL reset_max: got %0d want 0", out_max);         else passed++;
    checks++; if (out_min !== 4'd0)    $display("FAIL reset_min: got %0d want 0", out_min);         else passed++;
    checks++; if (out_count !== 8'd0)  $display("FAIL reset_count: got %0d want 0", out_count);     else passed++;
    checks++; if (out_all_eq !== 1'b1) $display("FAIL reset_all_eq: got %0d want 1", out_all_eq);   else passed++;
    checks++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %0d want 0", busy);           else passed++;
    rst = 1'b0;
  endtask

  task automatic test_mixed();
    out_ready = 1'b1;
    send(4'd5, 1'b0);
    send(4'd3, 1'b0);
    send(4'd9, 1'b0);
    send(4'd3, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL mixed_valid_k: got %0d want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b1)      $display("FAIL mixed_busy_k: got %0d want 1", busy);       else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL mixed_valid_k1: got %0d want 0", out_valid); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1)  $display("FAIL mixed_valid_k2: got %0d want 1", out_valid); else passed++;
    checks++; if (out_max !== 4'd9)    $display("FAIL mixed_max: got %0d want 9", out_max);         else passed++;
    checks++; if (out_min !== 4'd3)    $display("FAIL mixed_min: got %0d want 3", out_min);         else passed++;
    checks++; if (out_count !== 8'd4)  $display("FAIL mixed_count: got %0d want 4", out_count);     else passed++;
    checks++; if (out_all_eq !== 1'b0) $display("FAIL mixed_all_eq: got %0d want 0", out_all_eq);   else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL mixed_after_valid: got %0d want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1)  $display("FAIL mixed_after_ready: got %0d want 1", in_ready);  else passed++;
    checks++; if (busy !== 1'b0)      $display("FAIL mixed_after_busy: got %0d want 0", busy);       else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    send(4'd7, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1)  $display("FAIL single_valid: got %0d want 1", out_valid);   else passed++;
    checks++; if (out_max !== 4'd7)    $display("FAIL single_max: got %0d want 7", out_max);       else passed++;
    checks++; if (out_min !== 4'd7)    $display("FAIL single_min: got %0d want 7", out_min);       else passed++;
    checks++; if (out_count !== 8'd1)  $display("FAIL single_count: got %0d want 1", out_count);   else passed++;
    checks++; if (out_all_eq !== 1'b1) $display("FAIL single_all_eq: got %0d want 1", out_all_eq); else passed++;
    release_result();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL single_released: got %0d want 0", out_valid); else passed++;
  endtask

  task automatic test_boundary();
    send(4'd15, 1'b0);
    send(4'd15, 1'b0);
    send(4'd15, 1'b1);
    wait_done();
    checks++; if (out_max !== 4'd15)   $display("FAIL bnd_eq_max: got %0d want 15", out_max);     else passed++;
    checks++; if (out_min !== 4'd15)   $display("FAIL bnd_eq_min: got %0d want 15", out_min);     else passed++;
    checks++; if (out_count !== 8'd3)  $display("FAIL bnd_eq_count: got %0d want 3", out_count);  else passed++;
    checks++; if (out_all_eq !== 1'b1) $display("FAIL bnd_eq_all_eq: got %0d want 1", out_all_eq); else passed++;
    release_result();
    send(4'd0, 1'b0);
    send(4'd15, 1'b1);
    wait_done();
    checks++; if (out_max !== 4'd15)   $display("FAIL bnd_span_max: got %0d want 15", out_max);     else passed++;
    checks++; if (out_min !== 4'd0)    $display("FAIL bnd_span_min: got %0d want 0", out_min);      else passed++;
    checks++; if (out_count !== 8'd2)  $display("FAIL bnd_span_count: got %0d want 2", out_count);  else passed++;
    checks++; if (out_all_eq !== 1'b0) $display("FAIL bnd_span_all_eq: got %0d want 0", out_all_eq); else passed++;
    release_result();
  endtask

  task automatic test_backpressure();
    int acc[$];
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd2;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) acc.push_back(i);
      @(negedge clk);
    end
    checks++;
    if (acc.size() < 4) $display("FAIL bp_accepts: got %0d accepts want 4", acc.size());
    else passed++;
    if (acc.size() >= 4) begin
      checks++; if (acc[1] - acc[0] !== 1) $display("FAIL bp_first_gap: got %0d want 1", acc[1] - acc[0]); else passed++;
      checks++; if (acc[2] - acc[1] !== 3) $display("FAIL bp_gap_a: got %0d want 3", acc[2] - acc[1]);     else passed++;
      checks++; if (acc[3] - acc[2] !== 3) $display("FAIL bp_gap_b: got %0d want 3", acc[3] - acc[2]);     else passed++;
    end
    send(4'd2, 1'b1);
    wait_done();
    checks++; if (out_count !== 8'd6) $display("FAIL bp_count: got %0d want 6", out_count); else passed++;
    in_valid = 1'b1;
    in_data  = 4'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %0d want 1", i, out_valid); else passed++;
      checks++; if (in_ready !== 1'b0)  $display("FAIL bp_hold_ready[%0d]: got %0d want 0", i, in_ready);  else passed++;
      checks++; if (out_max !== 4'd2)   $display("FAIL bp_hold_max[%0d]: got %0d want 2", i, out_max);     else passed++;
      checks++; if (out_count !== 8'd6) $display("FAIL bp_hold_count[%0d]: got %0d want 6", i, out_count); else passed++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result();
    @(negedge clk);
    checks++; if (out_max !== 4'd2)   $display("FAIL bp_retain_max: got %0d want 2", out_max);     else passed++;
    checks++; if (out_count !== 8'd0) $display("FAIL bp_clear_count: got %0d want 0", out_count);  else passed++;
  endtask

  task automatic test_saturation();
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b0);
    send(4'd5, 1'b1);
    wait_done();
    checks++; if (s_out_count !== 2'd3) $display("FAIL sat_count: got %0d want 3", s_out_count); else passed++;
    checks++; if (s_out_max !== 4'd5)   $display("FAIL sat_max: got %0d want 5", s_out_max);     else passed++;
    checks++; if (s_out_min !== 4'd1)   $display("FAIL sat_min: got %0d want 1", s_out_min);     else passed++;
    checks++; if (out_count !== 8'd5)   $display("FAIL wide_count: got %0d want 5", out_count);  else passed++;
    release_result();
  endtask

  task automatic test_reset_midframe();
    send(4'd8, 1'b0);
    send(4'd6, 1'b0);
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL mid_pre_ready: got %0d want 0", in_ready); else passed++;
    checks++; if (busy !== 1'b1)     $display("FAIL mid_pre_busy: got %0d want 1", busy);     else passed++;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1)  $display("FAIL mid_rst_ready: got %0d want 1", in_ready);  else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0d want 0", out_valid); else passed++;
    checks++; if (out_count !== 8'd0) $display("FAIL mid_rst_count: got %0d want 0", out_count); else passed++;
    checks++; if (busy !== 1'b0)      $display("FAIL mid_rst_busy: got %0d want 0", busy);       else passed++;
    checks++; if (out_max !== 4'd0)   $display("FAIL mid_rst_max: got %0d want 0", out_max);     else passed++;
    @(negedge clk);
    rst = 1'b0;
    send(4'd4, 1'b1);
    wait_done();
    checks++; if (out_max !== 4'd4)    $display("FAIL mid_next_max: got %0d want 4", out_max);       else passed++;
    checks++; if (out_min !== 4'd4)    $display("FAIL mid_next_min: got %0d want 4", out_min);       else passed++;
    checks++; if (out_count !== 8'd1)  $display("FAIL mid_next_count: got %0d want 1", out_count);   else passed++;
    checks++; if (out_all_eq !== 1'b1) $display("FAIL mid_next_all_eq: got %0d want 1", out_all_eq); else passed++;
    release_result();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_mixed();
    test_single();
    test_boundary();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
